cmd_word_deser: RTL



---
 rtl/cmd_word_deser.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cmd_word_deser.sv
// Packet deserializer: header + N (lo,hi) word pairs -> 32-bit register writes with auto-incrementing address.
// Optional inter-word gap timeout is enabled by defining CMD_WORD_DESER_TIMEOUT_EN.
module cmd_word_deser #(
    parameter int TO_WIDTH  = 10,
    parameter int TO_CYCLES = 1000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_stb,
    output logic        we,
    output logic [7:0]  wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  addr, addr_nxt;
    logic [7:0]  remaining, remaining_nxt;
    logic [15:0] low_half, low_half_nxt;
    logic        we_nxt;
    logic [7:0]  wa_nxt;
    logic [31:0] wd_nxt;
    logic        done_nxt;
    logic        timeout_nxt;

    // The gap counter must be able to hold TO_CYCLES-1.
    if (TO_CYCLES < 1 || TO_CYCLES >= (1 << TO_WIDTH)) begin : g_bad_timeout
        $error("cmd_word_deser: TO_CYCLES must be in [1, 2**TO_WIDTH)");
    end

`ifdef CMD_WORD_DESER_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] GAP_LAST = TO_WIDTH'(TO_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] GAP_ONE  = TO_WIDTH'(1);
    logic [TO_WIDTH-1:0] gap_cnt, gap_cnt_nxt;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch inferred).
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        low_half_nxt  = low_half;
        we_nxt        = 1'b0;
        wa_nxt        = wa;
        wd_nxt        = wd;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (din_stb) begin
                    addr_nxt      = din[15:8];
                    remaining_nxt = din[7:0];
                    if (din[7:0] == 8'd0) done_nxt  = 1'b1;
                    else                  state_nxt = LO;
                end
            end
            LO: begin
                if (din_stb) begin
                    low_half_nxt = din;
                    state_nxt    = HI;
                end
            end
            HI: begin
                if (din_stb) begin
                    we_nxt        = 1'b1;
                    wa_nxt        = addr;
                    wd_nxt        = {din, low_half};
                    addr_nxt      = addr + 8'd1;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LO;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef CMD_WORD_DESER_TIMEOUT_EN
        gap_cnt_nxt = gap_cnt;
        if (state == IDLE || din_stb) begin
            gap_cnt_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
            // Abort the packet; the half-received pair is simply dropped.
            gap_cnt_nxt = '0;
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
        end else begin
            gap_cnt_nxt = gap_cnt + GAP_ONE;
        end
`endif
    end

    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state     <= IDLE;
            addr      <= 8'd0;
            remaining <= 8'd0;
            low_half  <= 16'd0;
            we        <= 1'b0;
            wa        <= 8'd0;
            wd        <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            low_half  <= low_half_nxt;
            we        <= we_nxt;
            wa        <= wa_nxt;
            wd        <= wd_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
        end
    end

`ifdef CMD_WORD_DESER_TIMEOUT_EN
    always_ff @(posedge mclk) begin
        if (rst) begin
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            gap_cnt     <= gap_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
